rx_frame_buffer: RTL and testbench
==================================

// Module: rx_frame_buffer
// PURPOSE
//  Sits directly downstream of rx. Captures one PCD->PICC frame's decoded bytes into a local buffer
//  and runs CRC_A over the full bytes. At end of frame it presents length, last-byte bit count,
//  CRC/parity/sequence status and random read access to the application layer, holding them until acknowledged.
// PARAMETERS
//  MAX_BYTES   16   buffer depth in bytes (>=3); LEN_W = $clog2(MAX_BYTES+1) derived locally
// PORTS
//  clk               in   1      system clock
//  rst               in   1      synchronous, active-high reset
//  rx_soc            in   1      start of frame pulse from rx
//  rx_eoc            in   1      end of frame pulse from rx
//  rx_data           in   8      received byte, LSB first on air
//  rx_data_bits      in   3      valid bits in rx_data; 0 = full byte
//  rx_data_valid     in   1      rx_data/rx_data_bits valid this cycle
//  rx_sequence_error in   1      sequence error pulse from rx
//  rx_parity_error   in   1      parity error pulse from rx
//  frame_ready       out  1      frame captured; outputs below stable while high
//  frame_ack         in   1      consumer releases the buffer
//  frame_len         out  LEN_W  bytes stored, partial last byte included
//  frame_last_bits   out  3      bits in last byte; 0 = whole bytes
//  frame_crc_ok      out  1      CRC_A residue 0, frame_len>=3, frame_last_bits==0, no errors
//  frame_error       out  1      parity or sequence error seen during frame
//  frame_overflow    out  1      more than MAX_BYTES bytes offered
//  frame_dropped     out  1      1-cycle pulse: rx_soc arrived while READY and no ack
//  rd_addr           in   LEN_W  buffer read index
//  rd_data           out  8      buffer[rd_addr], registered, 1-cycle latency
// BEHAVIOUR
//  Reset: state IDLE; frame_ready, frame_len, frame_last_bits, frame_crc_ok, frame_error,
//   frame_overflow, frame_dropped, rd_data all 0; crc <= 16'h6363. Buffer contents not reset.
//  FSM IDLE -> RECEIVE on rx_soc. All other rx inputs ignored in IDLE.
//  RECEIVE entry (rx_soc): cnt=0, crc=16'h6363, err=0, ovf=0, last_bits=0.
//  RECEIVE, rx_data_valid:
//   - cnt<MAX_BYTES: buf[cnt]<=rx_data; cnt++; last_bits<=rx_data_bits.
//   - cnt==MAX_BYTES: not stored, ovf=1, cnt saturates.
//   - rx_data_bits==0: crc updated over byte, LSB first: per bit b=crc[0]^d[i]; crc=(crc>>1)^(b?16'h8408:0).
//     Partial bytes are not fed to CRC.
//  RECEIVE, rx_parity_error|rx_sequence_error: err=1. Bytes after it are still stored.
//  RECEIVE, rx_eoc: -> READY next cycle. rx_data_valid in the same cycle is processed first.
//   Registers frame_len=cnt, frame_last_bits=last_bits, frame_error=err, frame_overflow=ovf.
//   frame_crc_ok = (crc==0)&&cnt>=3&&last_bits==0&&!err&&!ovf (crc includes any byte in that cycle).
//   frame_ready=1 in the cycle after rx_eoc.
//  RECEIVE, rx_soc without preceding rx_eoc: frame restarts (entry actions); no output change.
//  READY: frame_* held constant; rx inputs ignored except rx_soc -> frame_dropped pulse, stay READY.
//  READY, frame_ack: frame_ready=0 next cycle -> IDLE; other frame_* keep last value.
//   If rx_soc in the same cycle: ack wins; -> RECEIVE with entry actions; no frame_dropped.
//  frame_ack outside READY: ignored.
//  rd_data = buf[rd_addr] one cycle after rd_addr, in any state.
//   rd_addr>=MAX_BYTES returns 8'h00. Contents are valid only for addr<frame_len while frame_ready.
//  rst mid-frame or in READY: immediate return to reset values; the partial frame is lost.
// TESTING
//  soc; byte 0x26, bits=7, with eoc -> frame_ready, len=1, last_bits=7, crc_ok=0, rd[0]=0x26.
//  soc; 00 00 A0 1E full; eoc -> len=4, last_bits=0, crc_ok=1, error=0; rd[3]=0x1E next cycle.
//  soc; 12 34 26 CF -> crc_ok=1. Repeat with CF->CE -> crc_ok=0, error=0.
//  soc; 2 bytes; parity_error pulse; eoc -> frame_error=1, crc_ok=0, len=2.
//  MAX_BYTES+2 full bytes -> overflow=1, len=MAX_BYTES, crc_ok=0.
//  READY + rx_soc, no ack -> frame_dropped 1 cycle, frame outputs unchanged.
//   Then ack+soc same cycle -> new frame captured correctly.
//  rst asserted mid-RECEIVE -> all outputs 0 next cycle.
//   Following frame 00 00 A0 1E -> crc_ok=1 (CRC re-initialised).

Source files
------------

// File: rtl/rx_frame_buffer.sv
// Receive-side frame buffer: stores one decoded PCD->PICC frame, checks CRC_A
// and holds length/status plus random read access until the consumer acknowledges.
module rx_frame_buffer #(
   parameter int MAX_BYTES = 16,
   localparam int LEN_W = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_soc,
   input  logic             rx_eoc,
   input  logic [7:0]       rx_data,
   input  logic [2:0]       rx_data_bits,
   input  logic             rx_data_valid,
   input  logic             rx_sequence_error,
   input  logic             rx_parity_error,
   output logic             frame_ready,
   input  logic             frame_ack,
   output logic [LEN_W-1:0] frame_len,
   output logic [2:0]       frame_last_bits,
   output logic             frame_crc_ok,
   output logic             frame_error,
   output logic             frame_overflow,
   output logic             frame_dropped,
   input  logic [LEN_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);

   localparam int ADDR_W = $clog2(MAX_BYTES);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
   localparam logic [15:0] CRC_INIT = 16'h6363;

   typedef enum logic [1:0] {IDLE, RECEIVE, READY} state_t;

   state_t           state_reg;
   logic [LEN_W-1:0] cnt_reg, cnt_next;
   logic [15:0]      crc_reg, crc_next;
   logic [2:0]       last_bits_reg, last_bits_next;
   logic             err_reg, err_next;
   logic             ovf_reg, ovf_next;
   logic             wr_en;
   logic             crc_good;

   logic [7:0] mem [MAX_BYTES];

   // Reflected CRC_A (poly 0x8408), one byte, LSB first.
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
      end
      return r;
   endfunction

   // Per-cycle frame accumulation; the eoc cycle uses these so a byte arriving with eoc counts.
   always_comb begin
      cnt_next       = cnt_reg;
      crc_next       = crc_reg;
      last_bits_next = last_bits_reg;
      err_next       = err_reg;
      ovf_next       = ovf_reg;
      wr_en          = 1'b0;
      if (state_reg == RECEIVE && !rx_soc) begin
         if (rx_data_valid) begin
            if (cnt_reg < MAX_LEN) begin
               wr_en          = 1'b1;
               cnt_next       = cnt_reg + LEN_W'(1);
               last_bits_next = rx_data_bits;
            end else begin
               ovf_next = 1'b1;
            end
            if (rx_data_bits == 3'd0) begin
               crc_next = crc_byte(crc_reg, rx_data);
            end
         end
         if (rx_parity_error || rx_sequence_error) begin
            err_next = 1'b1;
         end
      end
   end

   assign crc_good = (crc_next == 16'h0000) && (cnt_next >= LEN_W'(3)) &&
                     (last_bits_next == 3'd0) && !err_next && !ovf_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         crc_reg         <= CRC_INIT;
         last_bits_reg   <= 3'd0;
         err_reg         <= 1'b0;
         ovf_reg         <= 1'b0;
         frame_ready     <= 1'b0;
         frame_len       <= '0;
         frame_last_bits <= 3'd0;
         frame_crc_ok    <= 1'b0;
         frame_error     <= 1'b0;
         frame_overflow  <= 1'b0;
         frame_dropped   <= 1'b0;
      end else begin
         frame_dropped <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rx_soc) begin
                  state_reg     <= RECEIVE;
                  cnt_reg       <= '0;
                  crc_reg       <= CRC_INIT;
                  last_bits_reg <= 3'd0;
                  err_reg       <= 1'b0;
                  ovf_reg       <= 1'b0;
               end
            end
            RECEIVE: begin
               if (rx_soc) begin
                  // Restart without a closing eoc: drop what was collected.
                  cnt_reg       <= '0;
                  crc_reg       <= CRC_INIT;
                  last_bits_reg <= 3'd0;
                  err_reg       <= 1'b0;
                  ovf_reg       <= 1'b0;
               end else begin
                  cnt_reg       <= cnt_next;
                  crc_reg       <= crc_next;
                  last_bits_reg <= last_bits_next;
                  err_reg       <= err_next;
                  ovf_reg       <= ovf_next;
                  if (rx_eoc) begin
                     state_reg       <= READY;
                     frame_ready     <= 1'b1;
                     frame_len       <= cnt_next;
                     frame_last_bits <= last_bits_next;
                     frame_error     <= err_next;
                     frame_overflow  <= ovf_next;
                     frame_crc_ok    <= crc_good;
                  end
               end
            end
            READY: begin
               if (frame_ack) begin
                  frame_ready <= 1'b0;
                  if (rx_soc) begin
                     state_reg     <= RECEIVE;
                     cnt_reg       <= '0;
                     crc_reg       <= CRC_INIT;
                     last_bits_reg <= 3'd0;
                     err_reg       <= 1'b0;
                     ovf_reg       <= 1'b0;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else if (rx_soc) begin
                  frame_dropped <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[cnt_reg[ADDR_W-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 8'h00;
      end else if (rd_addr < MAX_LEN) begin
         rd_data <= mem[rd_addr[ADDR_W-1:0]];
      end else begin
         rd_data <= 8'h00;
      end
   end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed and randomized frames against a queue-based reference of the frame buffer.
module tb_rx_frame_buffer;

   localparam int MAX = 16;
   localparam int LW  = $clog2(MAX + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_soc, rx_eoc, rx_data_valid, rx_sequence_error, rx_parity_error;
   logic [7:0]    rx_data;
   logic [2:0]    rx_data_bits;
   logic          frame_ready, frame_ack, frame_crc_ok, frame_error, frame_overflow, frame_dropped;
   logic [LW-1:0] frame_len, rd_addr;
   logic [2:0]    frame_last_bits;
   logic [7:0]    rd_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] q_data[$];
   logic [2:0] q_bits[$];
   bit         m_err;

   always #5 clk = ~clk;

   rx_frame_buffer #(.MAX_BYTES(MAX)) dut (
      .clk(clk), .rst(rst), .rx_soc(rx_soc), .rx_eoc(rx_eoc), .rx_data(rx_data),
      .rx_data_bits(rx_data_bits), .rx_data_valid(rx_data_valid),
      .rx_sequence_error(rx_sequence_error), .rx_parity_error(rx_parity_error),
      .frame_ready(frame_ready), .frame_ack(frame_ack), .frame_len(frame_len),
      .frame_last_bits(frame_last_bits), .frame_crc_ok(frame_crc_ok),
      .frame_error(frame_error), .frame_overflow(frame_overflow),
      .frame_dropped(frame_dropped), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic start_frame();
      q_data.delete();
      q_bits.delete();
      m_err  = 0;
      rx_soc = 1'b1;
      cyc();
      rx_soc = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic [2:0] b, input bit eoc);
      rx_data       = d;
      rx_data_bits  = b;
      rx_data_valid = 1'b1;
      rx_eoc        = eoc;
      cyc();
      rx_data_valid = 1'b0;
      rx_eoc        = 1'b0;
      rx_data       = 8'($urandom);
      rx_data_bits  = 3'($urandom);
      q_data.push_back(d);
      q_bits.push_back(b);
   endtask

   task automatic end_frame();
      rx_eoc = 1'b1;
      cyc();
      rx_eoc = 1'b0;
   endtask

   task automatic err_pulse(input bit par);
      if (par) rx_parity_error = 1'b1;
      else     rx_sequence_error = 1'b1;
      cyc();
      rx_parity_error   = 1'b0;
      rx_sequence_error = 1'b0;
      m_err = 1;
   endtask

   task automatic check_frame(input string name);
      int         n, len;
      logic [2:0] last;
      logic [15:0] crc;
      bit         ovf, ok;
      n    = q_data.size();
      len  = (n > MAX) ? MAX : n;
      last = (len > 0) ? q_bits[len-1] : 3'd0;
      ovf  = (n > MAX);
      crc  = 16'h6363;
      for (int i = 0; i < n; i++) if (q_bits[i] == 3'd0) crc = crc_step(crc, q_data[i]);
      ok = (crc == 16'h0000) && (len >= 3) && (last == 3'd0) && !m_err && !ovf;
      check({name, ".ready"}, frame_ready, 1);
      check({name, ".len"}, frame_len, len);
      check({name, ".last_bits"}, frame_last_bits, last);
      check({name, ".crc_ok"}, frame_crc_ok, ok);
      check({name, ".error"}, frame_error, m_err);
      check({name, ".overflow"}, frame_overflow, ovf);
      for (int i = 0; i < len; i++) begin
         rd_addr = LW'(i);
         cyc();
         check($sformatf("%s.rd[%0d]", name, i), rd_data, q_data[i]);
      end
      rd_addr = LW'(MAX);
      cyc();
      check({name, ".rd_oob"}, rd_data, 0);
      check({name, ".ready_hold"}, frame_ready, 1);
      $display("frame %s: bytes=%0d len=%0d last_bits=%0d crc_ok=%0d err=%0d ovf=%0d",
               name, n, len, last, ok, m_err, ovf);
   endtask

   task automatic ack();
      logic [LW-1:0] len_before;
      len_before = frame_len;
      frame_ack = 1'b1;
      cyc();
      frame_ack = 1'b0;
      check("ack.ready", frame_ready, 0);
      check("ack.len_kept", frame_len, len_before);
   endtask

   task automatic send_list(input logic [7:0] d[$]);
      for (int i = 0; i < d.size(); i++) send(d[i], 3'd0, 1'b0);
   endtask

   initial begin
      logic [7:0] dq[$];
      logic [2:0] bq[$];
      rst = 1'b1; rx_soc = 0; rx_eoc = 0; rx_data = 0; rx_data_bits = 0; rx_data_valid = 0;
      rx_sequence_error = 0; rx_parity_error = 0; frame_ack = 0; rd_addr = '0;
      cyc(); cyc();
      check("reset.ready", frame_ready, 0);
      check("reset.len", frame_len, 0);
      check("reset.crc_ok", frame_crc_ok, 0);
      check("reset.dropped", frame_dropped, 0);
      check("reset.rd_data", rd_data, 0);
      rst = 1'b0;
      cyc();

      // short 7-bit frame, byte together with eoc
      start_frame();
      send(8'h26, 3'd7, 1'b1);
      check_frame("reqa");
      ack();

      start_frame();
      dq = '{8'h00, 8'h00, 8'hA0, 8'h1E};
      send_list(dq);
      end_frame();
      check_frame("crc0000");
      ack();

      start_frame();
      dq = '{8'h12, 8'h34, 8'h26, 8'hCF};
      send_list(dq);
      end_frame();
      check("crc1234.ok", frame_crc_ok, 1);
      check_frame("crc1234");
      ack();

      start_frame();
      dq = '{8'h12, 8'h34, 8'h26, 8'hCE};
      send_list(dq);
      end_frame();
      check("crcbad.ok", frame_crc_ok, 0);
      check_frame("crcbad");
      ack();

      start_frame();
      send(8'h5A, 3'd0, 1'b0);
      send(8'hA5, 3'd0, 1'b0);
      err_pulse(1'b1);
      end_frame();
      check("parity.error", frame_error, 1);
      check_frame("parity");
      ack();

      start_frame();
      for (int i = 0; i < MAX + 2; i++) send(8'($urandom), 3'd0, 1'b0);
      end_frame();
      check("ovf.flag", frame_overflow, 1);
      check_frame("overflow");

      // soc while READY without ack: dropped pulse, frame untouched
      rx_soc = 1'b1;
      cyc();
      rx_soc = 1'b0;
      check("drop.pulse", frame_dropped, 1);
      check("drop.len", frame_len, MAX);
      check("drop.ready", frame_ready, 1);
      cyc();
      check("drop.pulse_end", frame_dropped, 0);
      check("drop.ready_hold", frame_ready, 1);

      // ack and soc together start the next frame directly
      q_data.delete(); q_bits.delete(); m_err = 0;
      frame_ack = 1'b1; rx_soc = 1'b1;
      cyc();
      frame_ack = 1'b0; rx_soc = 1'b0;
      check("acksoc.ready", frame_ready, 0);
      check("acksoc.dropped", frame_dropped, 0);
      dq = '{8'h00, 8'h00, 8'hA0, 8'h1E};
      send_list(dq);
      end_frame();
      check_frame("acksoc");
      ack();

      // reset in the middle of a frame
      start_frame();
      send(8'h77, 3'd0, 1'b0);
      send(8'h88, 3'd0, 1'b0);
      rd_addr = '0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rstmid.ready", frame_ready, 0);
      check("rstmid.len", frame_len, 0);
      check("rstmid.error", frame_error, 0);
      check("rstmid.rd_data", rd_data, 0);
      end_frame();
      check("rstmid.eoc_ignored", frame_ready, 0);
      start_frame();
      dq = '{8'h00, 8'h00, 8'hA0, 8'h1E};
      send_list(dq);
      end_frame();
      check("rstmid.crc_ok", frame_crc_ok, 1);
      check_frame("after_rst");
      ack();

      // randomized frames
      for (int it = 0; it < 20; it++) begin
         int n, kind, errpos;
         bit eoc_with;
         logic [15:0] c;
         n        = $urandom_range(1, MAX + 3);
         kind     = $urandom_range(0, 3);
         eoc_with = 1'($urandom_range(0, 1));
         dq.delete(); bq.delete();
         for (int i = 0; i < n; i++) begin
            dq.push_back(8'($urandom));
            bq.push_back(3'd0);
         end
         if (kind == 0 && n >= 3) begin
            c = 16'h6363;
            for (int i = 0; i < n - 2; i++) c = crc_step(c, dq[i]);
            dq[n-2] = c[7:0];
            dq[n-1] = c[15:8];
         end
         if (kind == 1) bq[n-1] = 3'($urandom_range(1, 7));
         errpos = (kind == 2) ? $urandom_range(0, n - 1) : -1;
         start_frame();
         for (int i = 0; i < n; i++) begin
            if (i == errpos) err_pulse(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) cyc();
            send(dq[i], bq[i], eoc_with && (i == n - 1));
         end
         if (!eoc_with) end_frame();
         check_frame($sformatf("rand%0d", it));
         ack();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
